// File: rtl/sync_ring_buffer.sv
// rtl/sync_ring_buffer.sv - single-clock ring buffer with level, status and sticky error flags
// Define RING_BUF_OVERWRITE_EN to overwrite the oldest entry on a push while full.
module sync_ring_buffer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 11,
  parameter int AFULL_TH = 2040
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              afull_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ovf_o,
  output logic              udf_o,
  input  logic              clr_err_i
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_L = (ADDR_W+1)'(AFULL_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, afull_q, empty_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              push_ok, pop_ok, full_push, underrun;

  always_comb begin
    pop_ok    = rd_en_i & ~empty_q;
    full_push = wr_en_i & full_q & ~rd_en_i;
    underrun  = rd_en_i & empty_q;
`ifdef RING_BUF_OVERWRITE_EN
    // A push into a full buffer evicts the oldest entry by dragging rptr along.
    push_ok = wr_en_i;
    rptr_d  = (pop_ok | full_push) ? rptr_q + 1'b1 : rptr_q;
`else
    push_ok = wr_en_i & ~full_push;
    rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
`endif
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    level_d = level_q;
    if (push_ok & ~pop_ok & ~full_push) begin
      level_d = level_q + 1'b1;
    end else if (pop_ok & ~push_ok) begin
      level_d = level_q - 1'b1;
    end
    ovf_d = clr_err_i ? 1'b0 : (ovf_q | full_push);
    udf_d = clr_err_i ? 1'b0 : (udf_q | underrun);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= (level_d == DEPTH_L);
      afull_q    <= (level_d >= AFULL_L);
      empty_q    <= (level_d == '0);
      rd_valid_q <= pop_ok;
      if (pop_ok) begin
        rd_data_q <= mem_q[rptr_q];
      end
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is deliberately left without reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (rstn_i && push_ok) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign full_o     = full_q;
  assign afull_o    = afull_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign ovf_o      = ovf_q;
  assign udf_o      = udf_q;

endmodule

// File: tb/tb_sync_ring_buffer.sv
// tb/tb_sync_ring_buffer.sv - self-checking bench for sync_ring_buffer
module tb_sync_ring_buffer;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 11;
  localparam int AFULL_TH = 2040;
  localparam int DEPTH    = 2 ** ADDR_W;
`ifdef RING_BUF_OVERWRITE_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full, afull, empty;
  logic [ADDR_W:0]   level;
  logic              ovf, udf;
  logic              clr_err;

  sync_ring_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH)) dut (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .full_o(full), .afull_o(afull), .empty_o(empty), .level_o(level),
    .ovf_o(ovf), .udf_o(udf), .clr_err_i(clr_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Reference model: a queue of stored bytes plus sticky flags.
  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] m_data = '0;
  bit m_valid = 0, m_ovf = 0, m_udf = 0;
  bit can_pop, was_full, err_o, err_u;
  logic [DATA_W-1:0] junk;

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      m_data  = '0;
      m_valid = 0;
      m_ovf   = 0;
      m_udf   = 0;
    end else begin
      can_pop  = rd_en && (mq.size() > 0);
      was_full = (mq.size() == DEPTH);
      err_o    = wr_en && was_full && !rd_en;
      err_u    = rd_en && (mq.size() == 0);
      m_valid  = can_pop;
      if (can_pop) m_data = mq.pop_front();
      if (wr_en) begin
        if (!was_full || can_pop) begin
          mq.push_back(wr_data);
        end else begin
`ifdef RING_BUF_OVERWRITE_EN
          junk = mq.pop_front();
          mq.push_back(wr_data);
`endif
        end
      end
      if (clr_err) begin
        m_ovf = 0;
        m_udf = 0;
      end else begin
        if (err_o) m_ovf = 1;
        if (err_u) m_udf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
      chk("m_afull", 32'(afull), 32'(mq.size() >= AFULL_TH));
      chk("m_rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("m_rd_data", 32'(rd_data), 32'(m_data));
      chk("m_ovf", 32'(ovf), 32'(m_ovf));
      chk("m_udf", 32'(udf), 32'(m_udf));
    end
  end

  task automatic cyc(input logic we, input int wd, input logic re, input logic ce);
    wr_en   = we;
    wr_data = 8'(wd);
    rd_en   = re;
    clr_err = ce;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_udf", 32'(udf), 0);
    rstn = 1'b1;
    cyc(0, 0, 0, 0);

    for (int i = 0; i < 16; i++) cyc(1, i, 0, 0);
    chk("seq_level", 32'(level), 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      chk("seq_data", 32'(rd_data), 32'(i));
      chk("seq_valid", 32'(rd_valid), 1);
    end
    cyc(0, 0, 0, 0);
    chk("seq_valid_end", 32'(rd_valid), 0);
    chk("seq_empty", 32'(empty), 1);

    for (int k = 1; k <= DEPTH; k++) begin
      cyc(1, (k - 1) & 255, 0, 0);
      if (k == AFULL_TH - 1) chk("afull_below", 32'(afull), 0);
      if (k == AFULL_TH)     chk("afull_at", 32'(afull), 1);
      if (k == DEPTH - 1)    chk("full_below", 32'(full), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 2048);
    cyc(1, 8'h00, 0, 0);
    chk("extra_ovf", 32'(ovf), 1);
    chk("extra_level", 32'(level), 2048);
    cyc(0, 0, 0, 1);
    chk("clr_ovf", 32'(ovf), 0);

    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'hE0 + i, 1, 0);
      chk("rw_data", 32'(rd_data), 32'(i + OFS));
      chk("rw_level", 32'(level), 2048);
      chk("rw_ovf", 32'(ovf), 0);
    end

    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("drain_empty", 32'(empty), 1);

    cyc(1, 8'hA5, 1, 0);
    chk("udf_set", 32'(udf), 1);
    chk("udf_level", 32'(level), 1);
    chk("udf_no_valid", 32'(rd_valid), 0);
    cyc(0, 0, 1, 0);
    chk("udf_pop_data", 32'(rd_data), 32'h A5);
    cyc(0, 0, 0, 1);
    chk("clr_udf", 32'(udf), 0);
    chk("clr_ovf2", 32'(ovf), 0);
    cyc(0, 0, 1, 1);
    chk("clr_priority", 32'(udf), 0);

    for (int i = 0; i < 1000; i++) cyc(1, i, 0, 0);
    chk("pre_rst_level", 32'(level), 1000);
    rstn = 1'b0;
    cyc(1, 8'h77, 1, 0);
    rstn = 1'b1;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_valid", 32'(rd_valid), 0);
    cyc(1, 8'h3C, 0, 0);
    cyc(0, 0, 1, 0);
    chk("post_rst_data", 32'(rd_data), 32'h3C);
    cyc(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
